timer_io_port: RTL and testbench
================================

Name: timer_io_port

Overview:
- CPU-side I/O port for the timer peripheral: the writer/reader end of the port-4 interface.
- Decodes CPU output operations to the timer configuration port and drives the timer's `umbral` and `basetiempo` inputs.
- Captures `timer_end` expiries into a sticky status register the CPU reads on a status port.
- Raises an interrupt request with an acknowledge handshake. Sits between the datapath I/O bus and the timer.

Parameters:
- ADDR_W, 3, I/O port address width.
- TIMER_PORT, 4, output-operation address of the config register: wdata[7:2] = umbral, wdata[1:0] = basetiempo.
- STATUS_PORT, 5, input-operation address of the expiry status register.
- CNT_W, 4, width of the saturating expiry counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- io_we  in  1  CPU output-operation strobe, one cycle.
- io_re  in  1  CPU input-operation strobe, one cycle.
- io_addr  in  ADDR_W  I/O port address.
- io_wdata  in  8  CPU output data.
- io_rdata  out  8  CPU input data, combinational from registers.
- umbral  out  6  timer threshold.
- basetiempo  out  2  timer time base select.
- timer_end  in  1  timer expiry level or pulse.
- int_req  out  1  interrupt request.
- int_ack  in  1  interrupt acknowledge, one cycle.

Behaviour:
- Reset (async, reset_n=0) clears:
  - config register, so umbral=0 and basetiempo=0;
  - state to IDLE;
  - expired, overrun, cnt;
  - int_req;
  - end_q, the registered previous value of timer_end.
- Reset release is followed by normal operation on the next rising edge. Reset mid-operation discards all status.
- Config write: io_we=1 and io_addr==TIMER_PORT loads io_wdata.
  - umbral and basetiempo update one clock after the strobe edge.
  - Writes to other addresses are ignored.
- Expiry event: timer_end rising edge (timer_end & ~end_q), one event per edge. A held-high level counts once.
- FSM states:
  - IDLE: umbral==0, timer disabled. Events are ignored.
  - RUNNING: a config write with umbral!=0 enters RUNNING and clears expired, overrun and cnt. An event moves to EXPIRED, sets expired=1 and int_req=1, and increments cnt.
  - EXPIRED: each further event sets overrun=1 and increments cnt. cnt saturates at 2^CNT_W-1 and never wraps.
- Status read: io_re=1 and io_addr==STATUS_PORT.
  - io_rdata = {expired, overrun, (6-CNT_W) zero bits, cnt}, showing the value before the clock edge.
  - At the edge, expired, overrun and cnt clear, and EXPIRED returns to RUNNING. int_req is not affected.
- Readback: io_re with io_addr==TIMER_PORT returns {umbral, basetiempo}. Other addresses return 8'h00.
- int_ack clears int_req at the next edge. int_req stays 1 until acknowledged or until a config write with umbral==0.
- Config write with umbral==0: go to IDLE and clear all status and int_req.
- Any config write while EXPIRED with umbral!=0: restart in RUNNING with status cleared.
- Simultaneous cases:
  - Event plus status read in the same cycle: the event wins. The read returns the pre-event value; afterwards expired=1, cnt=1, overrun=0, state EXPIRED.
  - Event plus int_ack in the same cycle: int_req stays 1, because the new event re-asserts it.
  - Event plus config write in the same cycle: the write wins and the event is dropped.
  - io_we plus io_re in the same cycle: both take effect.
- Latency: event at edge N gives status and int_req visible after edge N+1. The edge detector register is one stage.

Decomposition:
- Shared package `timer_io_pkg`:
  - TIMER_PORT and STATUS_PORT address constants;
  - 2-bit state typedef {IDLE, RUNNING, EXPIRED};
  - status bit positions STAT_EXPIRED=7 and STAT_OVERRUN=6;
  - config field slices.
- One natural sub-module, `rise_detect`: registered rising-edge detector producing the one-cycle event pulse from timer_end.

Test Plan:
- Reset, then write 8'b101010_11 to port 4 -> umbral=6'd42, basetiempo=2'd3 one cycle later; state RUNNING; read of port 4 returns 8'hAB.
- One timer_end pulse -> int_req=1; status read returns 8'h81; the next status read returns 8'h00.
- Three pulses without a read -> status 8'hC3. Twenty pulses -> cnt saturates and status reads 8'hCF.
- timer_end rising in the same cycle as a status read -> io_rdata=8'h00 for that read; the next read returns 8'h81.
- int_ack asserted with no new event -> int_req=0 next cycle. int_ack coincident with an event -> int_req stays 1.
- Write umbral=0 while EXPIRED -> state IDLE, int_req=0, later pulses ignored. Assert reset_n=0 asynchronously mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/timer_io_pkg.sv
// -----------------------------------------------------------------------------
// timer_io_pkg
// Shared definitions for the CPU-side timer I/O port: the default port
// addresses, the port FSM state type, the status byte bit positions and the
// helpers that split the configuration byte into its umbral/basetiempo fields.
// -----------------------------------------------------------------------------
package timer_io_pkg;

    // Default I/O port addresses (3-bit port address space).
    localparam logic [2:0] TIMER_PORT_ADDR  = 3'd4;
    localparam logic [2:0] STATUS_PORT_ADDR = 3'd5;

    // Port FSM: IDLE = timer disabled (umbral==0), RUNNING = armed with no
    // unread expiry, EXPIRED = at least one expiry not yet read by the CPU.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    // Status byte layout: {expired, overrun, zero pad, cnt}.
    localparam int STAT_EXPIRED = 7;
    localparam int STAT_OVERRUN = 6;

    // Configuration byte layout: {umbral[5:0], basetiempo[1:0]}.
    localparam int CFG_UMBRAL_MSB = 7;
    localparam int CFG_UMBRAL_LSB = 2;
    localparam int CFG_BASE_MSB   = 1;
    localparam int CFG_BASE_LSB   = 0;

    function automatic logic [5:0] cfg_umbral(input logic [7:0] cfg);
        return cfg[CFG_UMBRAL_MSB:CFG_UMBRAL_LSB];
    endfunction

    function automatic logic [1:0] cfg_base(input logic [7:0] cfg);
        return cfg[CFG_BASE_MSB:CFG_BASE_LSB];
    endfunction

endpackage

// File: rtl/timer_io_port_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector. Produces a one-cycle pulse for every
// low-to-high transition of sig_in; a level held high yields a single pulse.
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   sig_in   in   level or pulse to watch
//   rise     out  sig_in & ~(sig_in one cycle ago)
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);

    logic end_q;
    logic end_d;

    always_comb begin
        end_d = sig_in;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours regardless of evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            end_q <= 1'b0;
        end else begin
            end_q <= end_d;
        end
    end

    assign rise = sig_in & ~end_q;

endmodule

// File: rtl/timer_io_port.sv
// -----------------------------------------------------------------------------
// timer_io_port
// CPU-side I/O port for the timer peripheral. Decodes CPU output operations
// to the timer configuration register (driving umbral/basetiempo), captures
// timer_end expiries into a sticky status register readable on the status
// port, and raises an interrupt request cleared by int_ack.
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   io_we       in   CPU output-operation strobe
//   io_re       in   CPU input-operation strobe
//   io_addr     in   I/O port address
//   io_wdata    in   CPU output data
//   io_rdata    out  CPU input data (combinational from registers)
//   umbral      out  timer threshold
//   basetiempo  out  timer time base select
//   timer_end   in   timer expiry level or pulse
//   int_req     out  interrupt request
//   int_ack     in   interrupt acknowledge
// -----------------------------------------------------------------------------
module timer_io_port
    import timer_io_pkg::*;
#(
    parameter int                ADDR_W      = 3,
    parameter logic [ADDR_W-1:0] TIMER_PORT  = TIMER_PORT_ADDR,
    parameter logic [ADDR_W-1:0] STATUS_PORT = STATUS_PORT_ADDR,
    parameter int                CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_we,
    input  logic              io_re,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [7:0]        io_wdata,
    output logic [7:0]        io_rdata,
    output logic [5:0]        umbral,
    output logic [1:0]        basetiempo,
    input  logic              timer_end,
    output logic              int_req,
    input  logic              int_ack
);

    state_e           state_q, state_d;
    logic [7:0]       cfg_q, cfg_d;
    logic             expired_q, expired_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             int_req_q, int_req_d;

    logic   ev;
    logic   cfg_wr;
    logic   stat_rd;
    state_e state_rd;

    rise_detect u_rise_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (timer_end),
        .rise    (ev)
    );

    assign cfg_wr  = io_we && (io_addr == TIMER_PORT);
    assign stat_rd = io_re && (io_addr == STATUS_PORT);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        expired_d = expired_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        int_req_d = int_req_q;
        state_rd  = state_q;

        if (int_ack) begin
            int_req_d = 1'b0;
        end

        if (cfg_wr) begin
            // A config write restarts the port and drops any coincident event.
            cfg_d     = io_wdata;
            expired_d = 1'b0;
            overrun_d = 1'b0;
            cnt_d     = '0;
            if (cfg_umbral(io_wdata) == 6'd0) begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end else begin
                state_d = ST_RUNNING;
            end
        end else begin
            // The read-clear is applied first so a coincident event lands on
            // the cleared status and survives it.
            if (stat_rd) begin
                expired_d = 1'b0;
                overrun_d = 1'b0;
                cnt_d     = '0;
                if (state_q == ST_EXPIRED) begin
                    state_rd = ST_RUNNING;
                end
            end
            state_d = state_rd;

            if (ev) begin
                unique case (state_rd)
                    ST_RUNNING: begin
                        state_d   = ST_EXPIRED;
                        expired_d = 1'b1;
                        int_req_d = 1'b1;
                        cnt_d     = (cnt_d == '1) ? cnt_d : cnt_d + 1'b1;
                    end
                    ST_EXPIRED: begin
                        overrun_d = 1'b1;
                        int_req_d = 1'b1;
                        cnt_d     = (cnt_d == '1) ? cnt_d : cnt_d + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cfg_q     <= 8'h00;
            expired_q <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
            int_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            expired_q <= expired_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            int_req_q <= int_req_d;
        end
    end

    // Read mux shows register contents before the edge that may clear them.
    always_comb begin
        io_rdata = 8'h00;
        if (io_re) begin
            if (io_addr == TIMER_PORT) begin
                io_rdata = cfg_q;
            end else if (io_addr == STATUS_PORT) begin
                io_rdata = {expired_q, overrun_q, {(6 - CNT_W){1'b0}}, cnt_q};
            end
        end
    end

    assign umbral     = cfg_umbral(cfg_q);
    assign basetiempo = cfg_base(cfg_q);
    assign int_req    = int_req_q;

endmodule

// File: tb/tb_timer_io_port.sv
// -----------------------------------------------------------------------------
// tb_timer_io_port
// Directed bench for timer_io_port. A reference model tracks the port as
// "configuration byte + number of expiries since last clear + irq flag" and
// derives the expected outputs from that; a compare process checks every
// output on each falling edge, and the stimulus adds literal expectations.
// -----------------------------------------------------------------------------
module tb_timer_io_port;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       io_we = 1'b0;
    logic       io_re = 1'b0;
    logic [2:0] io_addr = 3'd0;
    logic [7:0] io_wdata = 8'h00;
    logic [7:0] io_rdata;
    logic [5:0] umbral;
    logic [1:0] basetiempo;
    logic       timer_end = 1'b0;
    logic       int_req;
    logic       int_ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    timer_io_port dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .io_we      (io_we),
        .io_re      (io_re),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .umbral     (umbral),
        .basetiempo (basetiempo),
        .timer_end  (timer_end),
        .int_req    (int_req),
        .int_ack    (int_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_cfg = 8'h00;
    int         m_events = 0;   // expiries since the last clear
    logic       m_int = 1'b0;
    logic       m_prev_end = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cfg      <= 8'h00;
            m_events   <= 0;
            m_int      <= 1'b0;
            m_prev_end <= 1'b0;
        end else begin
            logic ev, wr, rd, ack_clr;
            ev = timer_end && !m_prev_end;
            wr = io_we && io_addr == 3'd4;
            rd = io_re && io_addr == 3'd5;
            m_prev_end <= timer_end;
            ack_clr = int_ack || (wr && io_wdata[7:2] == 6'd0);
            if (wr) begin
                m_cfg    <= io_wdata;
                m_events <= 0;
                m_int    <= ack_clr ? 1'b0 : m_int;
            end else if (ev && m_cfg[7:2] != 6'd0) begin
                m_events <= (rd ? 0 : m_events) + 1;
                m_int    <= 1'b1;
            end else begin
                m_events <= rd ? 0 : m_events;
                m_int    <= ack_clr ? 1'b0 : m_int;
            end
        end
    end

    function automatic logic [7:0] model_rdata();
        int c;
        if (!io_re) return 8'h00;
        if (io_addr == 3'd4) return m_cfg;
        if (io_addr == 3'd5) begin
            c = (m_events > 15) ? 15 : m_events;
            return {m_events > 0, m_events > 1, 2'b00, 4'(c)};
        end
        return 8'h00;
    endfunction

    // Single compare process: inputs change just after rising edges, so the
    // falling edge sees stable inputs and settled outputs.
    always @(negedge clk) begin
        check("umbral",     {2'b00, umbral},     {2'b00, m_cfg[7:2]});
        check("basetiempo", {6'd0, basetiempo},  {6'd0, m_cfg[1:0]});
        check("int_req",    {7'd0, int_req},     {7'd0, m_int});
        check("io_rdata",   io_rdata,            model_rdata());
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cfg(input logic [2:0] addr, input logic [7:0] data);
        io_we = 1'b1; io_addr = addr; io_wdata = data;
        step();
        io_we = 1'b0;
    endtask

    task automatic rd_port(input string name, input logic [2:0] addr, input logic [7:0] exp);
        io_re = 1'b1; io_addr = addr;
        #2;
        check(name, io_rdata, exp);
        step();
        io_re = 1'b0;
    endtask

    task automatic pulse();
        timer_end = 1'b1;
        step();
        timer_end = 1'b0;
        step();
    endtask

    initial begin
        repeat (2) step();
        check("reset_umbral", {2'b00, umbral}, 8'h00);
        check("reset_int", {7'd0, int_req}, 8'h00);
        reset_n = 1'b1;
        step();

        // Configure and read back.
        wr_cfg(3'd4, 8'b101010_11);
        check("cfg_umbral", {2'b00, umbral}, 8'd42);
        check("cfg_base", {6'd0, basetiempo}, 8'd3);
        rd_port("readback_p4", 3'd4, 8'hAB);
        wr_cfg(3'd3, 8'h55);
        check("other_addr_ignored", {2'b00, umbral}, 8'd42);
        rd_port("readback_other", 3'd6, 8'h00);

        // Single expiry.
        pulse();
        check("irq_after_event", {7'd0, int_req}, 8'h01);
        rd_port("status_one", 3'd5, 8'h81);
        rd_port("status_cleared", 3'd5, 8'h00);
        check("irq_kept_by_read", {7'd0, int_req}, 8'h01);

        // Acknowledge without a new event.
        int_ack = 1'b1; step(); int_ack = 1'b0;
        check("irq_acked", {7'd0, int_req}, 8'h00);

        // Overrun and saturation.
        repeat (3) pulse();
        rd_port("status_three", 3'd5, 8'hC3);
        repeat (20) pulse();
        rd_port("status_sat", 3'd5, 8'hCF);

        // Event coincident with a status read: event wins.
        timer_end = 1'b1; io_re = 1'b1; io_addr = 3'd5;
        #2;
        check("read_with_event", io_rdata, 8'h00);
        step();
        io_re = 1'b0; timer_end = 1'b0;
        step();
        rd_port("after_read_event", 3'd5, 8'h81);

        // Ack, then ack coincident with an event.
        int_ack = 1'b1; step(); int_ack = 1'b0;
        check("irq_acked2", {7'd0, int_req}, 8'h00);
        timer_end = 1'b1; int_ack = 1'b1; step();
        int_ack = 1'b0; timer_end = 1'b0;
        check("ack_with_event", {7'd0, int_req}, 8'h01);
        step();

        // Disable while EXPIRED: irq drops, further pulses ignored.
        wr_cfg(3'd4, 8'h02);
        check("disable_int", {7'd0, int_req}, 8'h00);
        check("disable_umbral", {2'b00, umbral}, 8'h00);
        repeat (2) pulse();
        check("idle_no_irq", {7'd0, int_req}, 8'h00);
        rd_port("idle_status", 3'd5, 8'h00);

        // Re-arm, expire, then asynchronous reset mid-cycle.
        wr_cfg(3'd4, 8'hAB);
        pulse();
        check("rearm_irq", {7'd0, int_req}, 8'h01);
        io_re = 1'b1; io_addr = 3'd5;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_umbral", {2'b00, umbral}, 8'h00);
        check("async_rst_base", {6'd0, basetiempo}, 8'h00);
        check("async_rst_int", {7'd0, int_req}, 8'h00);
        check("async_rst_status", io_rdata, 8'h00);
        step();
        io_re = 1'b0;
        reset_n = 1'b1;
        step();
        wr_cfg(3'd4, 8'h5D);
        rd_port("post_reset_readback", 3'd4, 8'h5D);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
